mac_vec_unit: RTL

Parametrised, pipelined signed multiply-accumulate engine that reduces a stream of operand pairs into one dot-product result per vector. It is the successor to the single-shot 8-bit MAC and serves as the processing element of the systolic array. Input uses a valid/ready stream with an end-of-vector marker, and output uses a valid/ready result port. Data width, accumulator width and count width are configurable, and overflow is reported.

---
 rtl/mac_pkg.sv | 47 ++++
 rtl/mac_mul_stage.sv | 52 +++++
 rtl/mac_vec_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the vector MAC engine.
package mac_pkg;

    // Engine state: no partial sum, accumulating, last product in flight, result held.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Widest accumulator the helper below can handle (one guard bit is needed).
    localparam int SAT_MAX_W = 64;

    // Adds two w-bit signed values (passed sign-extended to 64 bits).
    // Returns the w-bit result, sign-extended, either wrapped or clamped.
    // ovf follows the classic rule: equal addend signs, different sum sign.
    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input  logic signed [SAT_MAX_W-1:0] a,
        input  logic signed [SAT_MAX_W-1:0] b,
        input  int unsigned                 w,
        input  logic                        sat,
        output logic                        ovf
    );
        logic signed [SAT_MAX_W-1:0] sum;
        logic signed [SAT_MAX_W-1:0] a_sh;
        logic signed [SAT_MAX_W-1:0] b_sh;
        logic signed [SAT_MAX_W-1:0] s_sh;
        logic signed [SAT_MAX_W-1:0] max_v;
        int unsigned                 sh;
        sh    = SAT_MAX_W - w;
        sum   = a + b;
        // Move bit w-1 of each operand to the top so its sign is bit 63.
        a_sh  = a <<< sh;
        b_sh  = b <<< sh;
        s_sh  = sum <<< sh;
        ovf   = (a_sh[SAT_MAX_W-1] == b_sh[SAT_MAX_W-1]) &&
                (s_sh[SAT_MAX_W-1] != a_sh[SAT_MAX_W-1]);
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (sat && ovf) begin
            sat_add = a_sh[SAT_MAX_W-1] ? ~max_v : max_v;
        end else begin
            sat_add = s_sh >>> sh;
        end
    endfunction

endpackage

// File: rtl/mac_mul_stage.sv
// Stage 1 of the MAC pipeline: registered signed product plus beat tags.
module mac_mul_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear_i,
    input  logic                       beat_i,
    input  logic                       first_i,
    input  logic                       last_i,
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    output logic signed [2*DATA_W-1:0] prod_o,
    output logic                       valid_o,
    output logic                       first_o,
    output logic                       last_o
);

    logic signed [2*DATA_W-1:0] prod_q;
    logic                       valid_q;
    logic                       first_q;
    logic                       last_q;

    // Capture the full-width product and its tags on each accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= beat_i;
            if (beat_i) begin
                prod_q  <= (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
                first_q <= first_i;
                last_q  <= last_i;
            end
        end
    end

    assign prod_o  = prod_q;
    assign valid_o = valid_q;
    assign first_o = first_q;
    assign last_o  = last_q;

endmodule

// File: rtl/mac_vec_unit.sv
// Pipelined signed dot-product engine: one result per in_last-terminated vector.
// Build option: define MAC_SAT_EN to clamp the accumulator instead of wrapping.
module mac_vec_unit
    import mac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_y,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_ovf
);

    if (ACC_W < 2*DATA_W) begin : g_acc_w_check
        $error("mac_vec_unit: ACC_W must be >= 2*DATA_W");
    end
    if (ACC_W > SAT_MAX_W - 1) begin : g_acc_max_check
        $error("mac_vec_unit: ACC_W must be <= 63");
    end

`ifdef MAC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_t                     state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       ovf_q, ovf_d;
    logic signed [ACC_W-1:0]    out_y_q, out_y_d;
    logic [CNT_W-1:0]           out_cnt_q, out_cnt_d;
    logic                       out_ovf_q, out_ovf_d;

    logic                       beat;
    logic signed [2*DATA_W-1:0] p_prod;
    logic                       p_valid, p_first, p_last;
    logic signed [ACC_W-1:0]    acc_base;
    logic signed [ACC_W-1:0]    acc_sum;
    logic                       step_ovf;

    assign in_ready  = !clear && (state_q == IDLE || state_q == ACCUM);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_y     = out_y_q;
    assign out_count = out_cnt_q;
    assign out_ovf   = out_ovf_q;

    mac_mul_stage #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (clear),
        .beat_i  (beat),
        .first_i (state_q == IDLE),
        .last_i  (in_last),
        .a_i     (in_a),
        .b_i     (in_b),
        .prod_o  (p_prod),
        .valid_o (p_valid),
        .first_o (p_first),
        .last_o  (p_last)
    );

    // Next state: clear wins, otherwise walk IDLE/ACCUM -> DRAIN -> HOLD -> IDLE.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (beat) state_d = in_last ? DRAIN : ACCUM;
                ACCUM:   if (beat && in_last) state_d = DRAIN;
                DRAIN:   state_d = HOLD;
                HOLD:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage 2: accumulate, count and track overflow; snapshot the result in DRAIN.
    always_comb begin
        acc_base  = p_first ? '0 : acc_q;
        step_ovf  = 1'b0;
        acc_sum   = ACC_W'(sat_add(64'(acc_base), 64'(p_prod), ACC_W, SAT_EN, step_ovf));
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_y_d   = out_y_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (p_valid) begin
                acc_d = acc_sum;
                ovf_d = (p_first ? 1'b0 : ovf_q) | step_ovf;
                if (p_first) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (state_q == DRAIN && p_last) begin
                out_y_d   = acc_d;
                out_cnt_d = cnt_d;
                out_ovf_d = ovf_d;
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_y_q   <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_y_q   <= out_y_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule
